// File: rtl/integral_scale_scheduler_if.sv
// Control bundle between the scale scheduler, frame control, the integral-image
// generator and the downstream detector.
interface integral_scale_scheduler_if #(
   parameter int unsigned X_WIDTH = 9,
   parameter int unsigned Y_WIDTH = 9
);
   logic               frame_start;
   logic               frame_busy;
   logic               frame_done;
   logic               err_timeout;
   logic               iig_ready;
   logic               iig_done;
   logic               iig_start;
   logic               iig_taken;
   logic [X_WIDTH-1:0] iig_sizeX;
   logic [Y_WIDTH-1:0] iig_sizeY;
   logic               det_valid;
   logic               det_ack;
   logic [3:0]         scale_idx;

   modport master (
      input  frame_start, iig_ready, iig_done, det_ack,
      output frame_busy, frame_done, err_timeout, iig_start, iig_taken,
             iig_sizeX, iig_sizeY, det_valid, scale_idx
   );

   modport slave (
      output frame_start, iig_ready, iig_done, det_ack,
      input  frame_busy, frame_done, err_timeout, iig_start, iig_taken,
             iig_sizeX, iig_sizeY, det_valid, scale_idx
   );
endinterface

// File: rtl/integral_scale_scheduler.sv
// Walks a geometric series of image sizes per frame, running one generator
// handshake and one detector handoff for each scale.
module integral_scale_scheduler #(
   parameter int unsigned X_WIDTH     = 9,
   parameter int unsigned Y_WIDTH     = 9,
   parameter int unsigned BASE_W      = 320,
   parameter int unsigned BASE_H      = 240,
   parameter int unsigned MIN_W       = 24,
   parameter int unsigned MIN_H       = 24,
   parameter int unsigned NUM_SCALES  = 8,
   parameter int unsigned SCALE_NUM   = 13,
   parameter int unsigned SCALE_SHIFT = 4,
   parameter int unsigned TIMEOUT_W   = 20
) (
   input logic                          clk,
   input logic                          reset,
   integral_scale_scheduler_if.master   bus
);

   typedef enum logic [2:0] {
      StIdle, StWaitReady, StStart, StRun, StHandoff, StTake, StNext, StFinish
   } state_e;

   localparam int unsigned PwX = X_WIDTH + 32;
   localparam int unsigned PwY = Y_WIDTH + 32;
   // Compared against the pre-increment count so the flag lands when the count hits all-ones.
   localparam logic [TIMEOUT_W-1:0] WdLast = ~TIMEOUT_W'(1);

   state_e                 state_q, state_d;
   logic [X_WIDTH-1:0]     cur_w_q, cur_w_d;
   logic [Y_WIDTH-1:0]     cur_h_q, cur_h_d;
   logic [3:0]             idx_q, idx_d;
   logic [TIMEOUT_W-1:0]   wd_cnt_q, wd_cnt_d;
   logic                   err_q, err_d;

   logic [PwX-1:0]         prod_w;
   logic [PwY-1:0]         prod_h;
   logic [X_WIDTH-1:0]     nw;
   logic [Y_WIDTH-1:0]     nh;
   logic                   last_scale;

   always_comb begin
      prod_w = PwX'(cur_w_q) * PwX'(SCALE_NUM);
      prod_h = PwY'(cur_h_q) * PwY'(SCALE_NUM);
      nw     = X_WIDTH'(prod_w >> SCALE_SHIFT);
      nh     = Y_WIDTH'(prod_h >> SCALE_SHIFT);
      // Current-size test covers an undersized base when the factor is not shrinking.
      last_scale = (32'(idx_q) == NUM_SCALES - 32'd1) ||
                   (32'(nw) < MIN_W) || (32'(nh) < MIN_H) ||
                   (32'(cur_w_q) < MIN_W) || (32'(cur_h_q) < MIN_H);
   end

   always_comb begin
      state_d  = state_q;
      cur_w_d  = cur_w_q;
      cur_h_d  = cur_h_q;
      idx_d    = idx_q;
      wd_cnt_d = wd_cnt_q;
      err_d    = err_q;

      bus.iig_start  = 1'b0;
      bus.iig_taken  = 1'b0;
      bus.det_valid  = 1'b0;
      bus.frame_done = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.frame_start) begin
               cur_w_d = X_WIDTH'(BASE_W);
               cur_h_d = Y_WIDTH'(BASE_H);
               idx_d   = '0;
               err_d   = 1'b0;
               state_d = StWaitReady;
            end
         end
         StWaitReady: begin
            if (bus.iig_ready) state_d = StStart;
         end
         StStart: begin
            bus.iig_start = 1'b1;
            wd_cnt_d      = '0;
            state_d       = StRun;
         end
         StRun: begin
            wd_cnt_d = wd_cnt_q + 1'b1;
            if (bus.iig_done) begin
               state_d = StHandoff;
            end else if (wd_cnt_q == WdLast) begin
               err_d   = 1'b1;
               state_d = StFinish;
            end
         end
         StHandoff: begin
            bus.det_valid = 1'b1;
            if (bus.det_ack) state_d = StTake;
         end
         StTake: begin
            bus.iig_taken = 1'b1;
            state_d       = StNext;
         end
         StNext: begin
            if (last_scale) begin
               state_d = StFinish;
            end else begin
               cur_w_d = nw;
               cur_h_d = nh;
               idx_d   = idx_q + 4'd1;
               state_d = StWaitReady;
            end
         end
         StFinish: begin
            bus.frame_done = 1'b1;
            state_d        = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.frame_busy  = (state_q != StIdle) && (state_q != StFinish);
      bus.err_timeout = err_q;
      bus.iig_sizeX   = (state_q == StIdle) ? '0 : cur_w_q;
      bus.iig_sizeY   = (state_q == StIdle) ? '0 : cur_h_q;
      bus.scale_idx   = (state_q == StIdle) ? '0 : idx_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         cur_w_q  <= X_WIDTH'(BASE_W);
         cur_h_q  <= Y_WIDTH'(BASE_H);
         idx_q    <= '0;
         wd_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cur_w_q  <= cur_w_d;
         cur_h_q  <= cur_h_d;
         idx_q    <= idx_d;
         wd_cnt_q <= wd_cnt_d;
         err_q    <= err_d;
      end
   end

endmodule
